// File: rtl/generador_vga_sync.sv
// 640x480 VGA raster timing: pixel/line counters, registered sync and active-video flags.
// Define SYNC_ACTIVE_LOW_EN for active-low hsync_o/vsync_o (standard 640x480 polarity).
module generador_vga_sync #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int DW       = 10
) (
    input  logic          clk_50MHz_i,
    input  logic          rst_sync_i,
    input  logic          enable_i,
    output logic [DW-1:0] pixel_x_o,
    output logic [DW-1:0] pixel_y_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          video_on_o,
    output logic          line_end_o,
    output logic          frame_end_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [DW-1:0] H_LAST   = DW'(H_TOTAL - 1);
    localparam logic [DW-1:0] V_LAST   = DW'(V_TOTAL - 1);
    localparam logic [DW-1:0] H_ACT_W  = DW'(H_ACTIVE);
    localparam logic [DW-1:0] V_ACT_W  = DW'(V_ACTIVE);
    localparam logic [DW-1:0] HS_START = DW'(H_ACTIVE + H_FP);
    localparam logic [DW-1:0] HS_END   = DW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [DW-1:0] VS_START = DW'(V_ACTIVE + V_FP);
    localparam logic [DW-1:0] VS_END   = DW'(V_ACTIVE + V_FP + V_SYNC);

`ifdef SYNC_ACTIVE_LOW_EN
    localparam logic SYNC_ON = 1'b0;
`else
    localparam logic SYNC_ON = 1'b1;
`endif
    localparam logic SYNC_OFF = ~SYNC_ON;

    logic [DW-1:0] r_x;
    logic [DW-1:0] r_y;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_video;

    logic          w_h_wrap;
    logic          w_v_wrap;
    logic [DW-1:0] w_x_next;
    logic [DW-1:0] w_y_next;
    logic          w_hsync_next;
    logic          w_vsync_next;
    logic          w_video_next;

    // >= rather than == so an out-of-range count falls back to 0 on the next tick.
    assign w_h_wrap = (r_x >= H_LAST);
    assign w_v_wrap = (r_y >= V_LAST);
    assign w_x_next = w_h_wrap ? '0 : r_x + DW'(1);
    assign w_y_next = !w_h_wrap ? r_y : (w_v_wrap ? '0 : r_y + DW'(1));

    // Decode from the next counter values so the flags land on the same edge as the counters.
    assign w_hsync_next = ((w_x_next >= HS_START) && (w_x_next < HS_END)) ? SYNC_ON : SYNC_OFF;
    assign w_vsync_next = ((w_y_next >= VS_START) && (w_y_next < VS_END)) ? SYNC_ON : SYNC_OFF;
    assign w_video_next = (w_x_next < H_ACT_W) && (w_y_next < V_ACT_W);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_50MHz_i) begin
        if (rst_sync_i) begin
            r_x     <= '0;
            r_y     <= '0;
            r_hsync <= SYNC_OFF;
            r_vsync <= SYNC_OFF;
            r_video <= 1'b1;
        end else if (enable_i) begin
            r_x     <= w_x_next;
            r_y     <= w_y_next;
            r_hsync <= w_hsync_next;
            r_vsync <= w_vsync_next;
            r_video <= w_video_next;
        end
    end

    assign pixel_x_o   = r_x;
    assign pixel_y_o   = r_y;
    assign hsync_o     = r_hsync;
    assign vsync_o     = r_vsync;
    assign video_on_o  = r_video;
    assign line_end_o  = enable_i && (r_x == H_LAST);
    assign frame_end_o = line_end_o && (r_y == V_LAST);

endmodule

// File: tb/tb_generador_vga_sync.sv
// Bench for generador_vga_sync: a default-timing instance and a shrunken-raster instance
// checked every cycle against a linear tick-index model, plus literal raster landmarks.
module tb_generador_vga_sync;

`ifdef SYNC_ACTIVE_LOW_EN
    localparam logic SYNC_ON = 1'b0;
`else
    localparam logic SYNC_ON = 1'b1;
`endif
    localparam logic SYNC_OFF = ~SYNC_ON;

    // Small raster: H 40/4/8/6 = 58, V 20/2/2/3 = 27, so one frame is 1566 ticks.
    localparam int SH_A = 40, SH_F = 4, SH_S = 8, SH_B = 6;
    localparam int SV_A = 20, SV_F = 2, SV_S = 2, SV_B = 3;
    localparam int FD = 800 * 525;
    localparam int FS = 58 * 27;

    logic       clk;
    logic       rst;
    logic       en;

    logic [9:0] d_x, d_y;
    logic       d_hs, d_vs, d_vid, d_le, d_fe;
    logic [5:0] s_x, s_y;
    logic       s_hs, s_vs, s_vid, s_le, s_fe;

    int n_checks = 0;
    int n_err    = 0;
    int td = 0, ts = 0;
    bit armed = 0;

    generador_vga_sync u_dut_def (
        .clk_50MHz_i(clk), .rst_sync_i(rst), .enable_i(en),
        .pixel_x_o(d_x), .pixel_y_o(d_y), .hsync_o(d_hs), .vsync_o(d_vs),
        .video_on_o(d_vid), .line_end_o(d_le), .frame_end_o(d_fe)
    );

    generador_vga_sync #(
        .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
        .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B), .DW(6)
    ) u_dut_small (
        .clk_50MHz_i(clk), .rst_sync_i(rst), .enable_i(en),
        .pixel_x_o(s_x), .pixel_y_o(s_y), .hsync_o(s_hs), .vsync_o(s_vs),
        .video_on_o(s_vid), .line_end_o(s_le), .frame_end_o(s_fe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: position is a linear tick index within the frame; everything follows from it.
    task automatic model_out(input int t, input int ha, hf, hs_w, hb, va, vf, vs_w, vb,
                             input logic e, output int x, output int y,
                             output logic hs, output logic vs, output logic vid,
                             output logic le, output logic fe);
        int htot, vtot;
        htot = ha + hf + hs_w + hb;
        vtot = va + vf + vs_w + vb;
        x   = t % htot;
        y   = t / htot;
        hs  = (x >= ha + hf && x < ha + hf + hs_w) ? SYNC_ON : SYNC_OFF;
        vs  = (y >= va + vf && y < va + vf + vs_w) ? SYNC_ON : SYNC_OFF;
        vid = (x < ha) && (y < va);
        le  = e && (x == htot - 1);
        fe  = le && (y == vtot - 1);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            td = 0;
            ts = 0;
            armed = 1;
        end else if (en) begin
            td = (td + 1) % FD;
            ts = (ts + 1) % FS;
        end
    end

    always @(negedge clk) begin
        int ex, ey;
        logic ehs, evs, evid, ele, efe;
        if (armed) begin
            model_out(td, 640, 16, 96, 48, 480, 10, 2, 33, en, ex, ey, ehs, evs, evid, ele, efe);
            check("def_x", d_x, ex);
            check("def_y", d_y, ey);
            check("def_hsync", d_hs, ehs);
            check("def_vsync", d_vs, evs);
            check("def_video", d_vid, evid);
            check("def_line_end", d_le, ele);
            check("def_frame_end", d_fe, efe);
            model_out(ts, SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, en,
                      ex, ey, ehs, evs, evid, ele, efe);
            check("small_x", s_x, ex);
            check("small_y", s_y, ey);
            check("small_hsync", s_hs, ehs);
            check("small_vsync", s_vs, evs);
            check("small_video", s_vid, evid);
            check("small_line_end", s_le, ele);
            check("small_frame_end", s_fe, efe);
        end
    end

    // Landmark recorders for the line sweep (default raster) and the frame run (small raster).
    bit   mon_line = 0, mon_frame = 0;
    logic prev_vid, prev_hs;
    int   vid_fall_x = -1, hs_on_x = -1, hs_off_x = -1, le_cnt = 0, le_x = -1;
    int   fe_cnt = 0, fe_x = -1, fe_y = -1, vs_ticks = 0, vid_bad = 0;

    always @(negedge clk) begin
        if (mon_line) begin
            if (prev_vid && !d_vid && vid_fall_x < 0) vid_fall_x = int'(d_x);
            if (d_hs == SYNC_ON && prev_hs != SYNC_ON && hs_on_x < 0) hs_on_x = int'(d_x);
            if (d_hs != SYNC_ON && prev_hs == SYNC_ON && hs_off_x < 0) hs_off_x = int'(d_x);
            if (d_le) begin
                le_cnt++;
                le_x = int'(d_x);
            end
            prev_vid = d_vid;
            prev_hs  = d_hs;
        end
        if (mon_frame) begin
            if (s_fe) begin
                fe_cnt++;
                fe_x = int'(s_x);
                fe_y = int'(s_y);
            end
            if (en && s_vs == SYNC_ON) vs_ticks++;
            if (s_vid && s_y >= 6'(SV_A)) vid_bad++;
        end
    end

    task automatic step(input logic r, input logic e);
        rst = r;
        en  = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;

        // Reset with enable toggling.
        step(1, 1);
        step(1, 0);
        step(1, 1);
        check("rst_x", d_x, 0);
        check("rst_y", d_y, 0);
        check("rst_video", d_vid, 1);
        check("rst_hsync", d_hs, SYNC_OFF);
        check("rst_vsync", d_vs, SYNC_OFF);
        check("rst_line_end", d_le, 0);

        // Line sweep, one tick every second clock.
        prev_vid = 1'b1;
        prev_hs  = SYNC_OFF;
        mon_line = 1;
        for (int i = 0; i < 800; i++) begin
            step(0, 1);
            step(0, 0);
        end
        mon_line = 0;
        check("sweep_video_fall_x", vid_fall_x, 640);
        check("sweep_hsync_on_x", hs_on_x, 656);
        check("sweep_hsync_off_x", hs_off_x, 752);
        check("sweep_line_end_count", le_cnt, 1);
        check("sweep_line_end_x", le_x, 799);
        check("sweep_next_x", d_x, 0);
        check("sweep_next_y", d_y, 1);

        // Stall at x = 300 (consecutive ticks on the way there).
        for (int i = 0; i < 300; i++) step(0, 1);
        check("stall_x", d_x, 300);
        for (int i = 0; i < 10; i++) begin
            step(0, 0);
            check("stall_hold_x", d_x, 300);
            check("stall_line_end", d_le, 0);
        end
        step(0, 1);
        check("stall_resume_x", d_x, 301);

        // Full frame of the small raster from a clean reset.
        step(1, 1);
        check("small_rst_x", s_x, 0);
        check("small_rst_y", s_y, 0);
        mon_frame = 1;
        for (int i = 0; i < FS; i++) step(0, 1);
        mon_frame = 0;
        check("frame_end_count", fe_cnt, 1);
        check("frame_end_x", fe_x, 57);
        check("frame_end_y", fe_y, 26);
        check("frame_vsync_ticks", vs_ticks, SV_S * 58);
        check("frame_video_in_vblank", vid_bad, 0);
        check("frame_return_x", s_x, 0);
        check("frame_return_y", s_y, 0);

        // Reset mid-frame together with enable.
        for (int i = 0; i < 15 * 58 + 30; i++) step(0, 1);
        check("mid_x", s_x, 30);
        check("mid_y", s_y, 15);
        step(1, 1);
        check("midrst_small_x", s_x, 0);
        check("midrst_small_y", s_y, 0);
        check("midrst_def_x", d_x, 0);
        check("midrst_def_y", d_y, 0);
        check("midrst_hsync", s_hs, SYNC_OFF);
        check("midrst_vsync", s_vs, SYNC_OFF);
        check("midrst_video", s_vid, 1);

        // Random enables with rare resets, checked cycle by cycle against the model.
        for (int i = 0; i < 6000; i++)
            step(($urandom_range(0, 499) == 0), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 2000; i++) step(0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
